mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage, fed through ex_mem_reg.
- Performs loads and stores against the D-cache using a req/ack handshake, with byte-lane steering and load sign/zero extension.
- Non-memory instructions pass straight through.
- Freezes the front of the pipeline with mem_stall_o until the cache access finishes, then presents the writeback data to mem_wb_reg.

---
 rtl/mem_stage_pkg.sv | 57 +++++
 rtl/mem_load_align.sv | 38 +++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: width codes, load/store codes,
// FSM state encoding and byte-lane helpers used by mem_stage and its aligner.
package mem_stage_pkg;

    // Access width codes as carried on ex_mem_reg_mem_width_i (2'b11 acts as word)
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    // Direction codes as carried on ex_mem_reg_mem_rw_i
    localparam logic MEM_STORE = 1'b1;
    localparam logic MEM_LOAD  = 1'b0;

    // Cache access sequencing
    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_BUSY = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_e;

    // Byte strobes for a store of the given width at the given byte offset
    function automatic logic [3:0] calc_wstrb(input logic [1:0] width,
                                              input logic [1:0] offset);
        logic [3:0] strb;
        case (width)
            MEM_B:   strb = 4'b0001 << offset;
            MEM_H:   strb = 4'b0011 << {offset[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate right-aligned store data across every lane it could land in
    function automatic logic [31:0] steer_wdata(input logic [1:0]  width,
                                                input logic [31:0] data);
        logic [31:0] steered;
        case (width)
            MEM_B:   steered = {4{data[7:0]}};
            MEM_H:   steered = {2{data[15:0]}};
            default: steered = data;
        endcase
        return steered;
    endfunction

    // True when the access does not sit on its natural alignment
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] offset);
        logic mis;
        case (width)
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = offset[0];
            default: mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/half out of a read word and
// sign- or zero-extends it to 32 bits. Word accesses pass the word unchanged.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        rdtype,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Split the read word into its four byte lanes
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected field according to width and signedness
    always_comb begin
        data = rdata;
        case (width)
            MEM_B:   data = rdtype ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MEM_H:   data = rdtype ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores to the D-cache over a req/ack
// handshake, stalls the front of the pipe while the access is outstanding and
// presents writeback data to mem_wb_reg.
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned half/word accesses
// skip the cache, suppress writeback and pulse mem_misalign_o.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_mem_reg_op_c_i,
    input  logic [4:0]  ex_mem_reg_reg_waddr_i,
    input  logic        ex_mem_reg_reg_we_i,
    input  logic        ex_mem_reg_mtype_i,
    input  logic        ex_mem_reg_mem_rw_i,
    input  logic [1:0]  ex_mem_reg_mem_width_i,
    input  logic [31:0] ex_mem_reg_mem_wr_data_i,
    input  logic        ex_mem_reg_mem_rdtype_i,
    input  logic [31:0] ex_mem_reg_mem_addr_i,
    output logic        mem_dcache_req_o,
    output logic        mem_dcache_we_o,
    output logic [31:0] mem_dcache_addr_o,
    output logic [31:0] mem_dcache_wdata_o,
    output logic [3:0]  mem_dcache_wstrb_o,
    input  logic        dcache_mem_ack_i,
    input  logic [31:0] dcache_mem_rdata_i,
    output logic [31:0] mem_reg_wdata_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic        mem_reg_we_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        mem_misalign_o,
`endif
    output logic        mem_stall_o
);

    mem_state_e  state_reg;
    mem_state_e  state_next;
    logic [31:0] rdata_reg;
    logic [31:0] load_data;
    logic        req_int;
    logic        is_store;
    logic        misalign_hit;

    assign is_store = (ex_mem_reg_mem_rw_i == MEM_STORE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_hit   = ex_mem_reg_mtype_i &
                            is_misaligned(ex_mem_reg_mem_width_i, ex_mem_reg_mem_addr_i[1:0]);
    assign mem_misalign_o = (state_reg == MEM_DONE) & misalign_hit;
`else
    assign misalign_hit   = 1'b0;
`endif

    // FSM state register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MEM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the read word on the completing ack; acks outside BUSY are stray
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (state_reg == MEM_BUSY && dcache_mem_ack_i) begin
            rdata_reg <= dcache_mem_rdata_i;
        end
    end

    mem_load_align u_load_align (
        .rdata  (rdata_reg),
        .addr   (ex_mem_reg_mem_addr_i[1:0]),
        .width  (ex_mem_reg_mem_width_i),
        .rdtype (ex_mem_reg_mem_rdtype_i),
        .data   (load_data)
    );

    // Next-state, stall and writeback selection
    always_comb begin
        state_next      = state_reg;
        req_int         = 1'b0;
        mem_stall_o     = 1'b0;
        mem_reg_wdata_o = ex_mem_reg_op_c_i;
        mem_reg_we_o    = ex_mem_reg_reg_we_i;
        case (state_reg)
            MEM_IDLE: begin
                if (ex_mem_reg_mtype_i) begin
                    mem_stall_o  = 1'b1;
                    mem_reg_we_o = 1'b0;
                    if (misalign_hit) begin
                        state_next = MEM_DONE;
                    end else begin
                        req_int    = 1'b1;
                        state_next = MEM_BUSY;
                    end
                end
            end
            MEM_BUSY: begin
                req_int      = 1'b1;
                mem_stall_o  = 1'b1;
                mem_reg_we_o = 1'b0;
                if (dcache_mem_ack_i) begin
                    state_next = MEM_DONE;
                end
            end
            MEM_DONE: begin
                state_next = MEM_IDLE;
                if (misalign_hit) begin
                    mem_reg_we_o = 1'b0;
                end else if (!is_store) begin
                    mem_reg_wdata_o = load_data;
                end
            end
            default: begin
                state_next = MEM_IDLE;
            end
        endcase
    end

    // Cache request side; request qualifiers are forced low while in reset
    assign mem_dcache_req_o   = req_int & rst_n;
    assign mem_dcache_we_o    = mem_dcache_req_o & is_store;
    assign mem_dcache_wstrb_o = (mem_dcache_req_o & is_store)
                                ? calc_wstrb(ex_mem_reg_mem_width_i, ex_mem_reg_mem_addr_i[1:0])
                                : 4'b0000;
    assign mem_dcache_addr_o  = {ex_mem_reg_mem_addr_i[31:2], 2'b00};
    assign mem_dcache_wdata_o = steer_wdata(ex_mem_reg_mem_width_i, ex_mem_reg_mem_wr_data_i);
    assign mem_reg_waddr_o    = ex_mem_reg_reg_waddr_i;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by random
// transactions, checked against a byte-lane reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op_c = '0;
    logic [4:0]  waddr = '0;
    logic        reg_we = 1'b0;
    logic        mtype = 1'b0;
    logic        mem_rw = 1'b0;
    logic [1:0]  width = '0;
    logic [31:0] wr_data = '0;
    logic        rdtype = 1'b0;
    logic [31:0] addr = '0;
    logic        ack = 1'b0;
    logic [31:0] rdata_in = '0;

    logic        dc_req, dc_we, wb_we, stall;
    logic [31:0] dc_addr, dc_wdata, wb_wdata;
    logic [3:0]  dc_wstrb;
    logic [4:0]  wb_waddr;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .ex_mem_reg_op_c_i        (op_c),
        .ex_mem_reg_reg_waddr_i   (waddr),
        .ex_mem_reg_reg_we_i      (reg_we),
        .ex_mem_reg_mtype_i       (mtype),
        .ex_mem_reg_mem_rw_i      (mem_rw),
        .ex_mem_reg_mem_width_i   (width),
        .ex_mem_reg_mem_wr_data_i (wr_data),
        .ex_mem_reg_mem_rdtype_i  (rdtype),
        .ex_mem_reg_mem_addr_i    (addr),
        .mem_dcache_req_o         (dc_req),
        .mem_dcache_we_o          (dc_we),
        .mem_dcache_addr_o        (dc_addr),
        .mem_dcache_wdata_o       (dc_wdata),
        .mem_dcache_wstrb_o       (dc_wstrb),
        .dcache_mem_ack_i         (ack),
        .dcache_mem_rdata_i       (rdata_in),
        .mem_reg_wdata_o          (wb_wdata),
        .mem_reg_waddr_o          (wb_waddr),
        .mem_reg_we_o             (wb_we),
`ifdef MEM_MISALIGN_CHECK_EN
        .mem_misalign_o           (misalign),
`endif
        .mem_stall_o              (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] w);
        return (w == 2'b00) ? 1 : ((w == 2'b01) ? 2 : 4);
    endfunction

    // Reference load result: shift the naturally aligned field down, then extend
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] w, input bit uns);
        int sz = size_of(w);
        int off = int'(a[1:0]) & ~(sz - 1);
        logic [31:0] mask, v;
        if (sz == 4) return word;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = (word >> (8 * off)) & mask;
        if (!uns && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete transaction: IDLE cycle, k BUSY cycles, DONE cycle
    task automatic run_op(input string name, input bit mt, input bit rw, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                          input bit uns, input bit rwe, input int k, input logic [31:0] rd,
                          input bit ack_idle);
        int sz = size_of(w);
        int off = int'(a[1:0]) & ~(sz - 1);
        int stall_cnt;
        bit mis = 1'b0;
        logic [3:0]  exp_strb = '0;
        logic [31:0] exp_wd = '0;
        logic [31:0] exp_wb;
        logic [4:0]  ra = 5'($urandom);
`ifdef MEM_MISALIGN_CHECK_EN
        mis = mt && (int'(a[1:0]) != off);
`endif
        for (int b = 0; b < 4; b++) begin
            if (rw && b >= off && b < off + sz) exp_strb[b] = 1'b1;
            exp_wd[8*b +: 8] = 8'(sd >> (8 * (b % sz)));
        end
        @(negedge clk);
        mtype = mt; mem_rw = rw; width = w; addr = a; wr_data = sd; op_c = alu;
        rdtype = uns; reg_we = rwe; waddr = ra; ack = ack_idle; rdata_in = $urandom;
        #1;
        chk({name, ".idle_stall"}, 32'(stall), 32'(mt));
        if (!mt) begin
            chk({name, ".pass_req"}, 32'(dc_req), 32'd0);
            chk({name, ".pass_wdata"}, wb_wdata, alu);
            chk({name, ".pass_we"}, 32'(wb_we), 32'(rwe));
            chk({name, ".pass_waddr"}, 32'(wb_waddr), 32'(ra));
            $display("%s: pass-through op_c=%h we=%0d", name, alu, rwe);
            return;
        end
        if (mis) begin
`ifdef MEM_MISALIGN_CHECK_EN
            chk({name, ".mis_req"}, 32'(dc_req), 32'd0);
            @(negedge clk); ack = 1'b0; #1;
            chk({name, ".mis_stall"}, 32'(stall), 32'd0);
            chk({name, ".mis_flag"}, 32'(misalign), 32'd1);
            chk({name, ".mis_we"}, 32'(wb_we), 32'd0);
            $display("%s: misaligned addr=%h width=%0d suppressed", name, a, w);
`endif
            return;
        end
        chk({name, ".req"}, 32'(dc_req), 32'd1);
        chk({name, ".dc_we"}, 32'(dc_we), 32'(rw));
        chk({name, ".dc_addr"}, dc_addr, a & 32'hFFFF_FFFC);
        chk({name, ".wstrb"}, 32'(dc_wstrb), 32'(exp_strb));
        if (rw) chk({name, ".dc_wdata"}, dc_wdata, exp_wd);
        stall_cnt = 1;
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            ack = (c == k);
            rdata_in = (c == k) ? rd : $urandom;
            #1;
            chk({name, ".busy_req"}, 32'(dc_req), 32'd1);
            stall_cnt += int'(stall);
        end
        @(negedge clk); ack = 1'b0; rdata_in = $urandom; #1;
        exp_wb = rw ? alu : model_load(rd, a, w, uns);
        chk({name, ".done_stall"}, 32'(stall), 32'd0);
        chk({name, ".done_req"}, 32'(dc_req), 32'd0);
        chk({name, ".stall_len"}, 32'(stall_cnt), 32'(k + 1));
        chk({name, ".wb_wdata"}, wb_wdata, exp_wb);
        chk({name, ".wb_we"}, 32'(wb_we), 32'(rwe));
        chk({name, ".wb_waddr"}, 32'(wb_waddr), 32'(ra));
        $display("%s: %s w=%0d addr=%h k=%0d wb=%h strb=%b", name, rw ? "store" : "load",
                 w, a, k, wb_wdata, dc_wstrb);
    endtask

    initial begin
        // Reset state, with a memory op presented to exercise output gating
        mtype = 1'b1; mem_rw = 1'b1; addr = 32'h0000_0010; op_c = 32'h55;
        #2;
        chk("rst.req", 32'(dc_req), 32'd0);
        chk("rst.dc_we", 32'(dc_we), 32'd0);
        chk("rst.wstrb", 32'(dc_wstrb), 32'd0);
        chk("rst.stall", 32'(stall), 32'd1);
        mtype = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        $display("reset: outputs gated");

        run_op("add", 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 1'b1, 1, 32'h0, 1'b0);
        run_op("lb", 1'b1, 1'b0, 2'b00, 32'h103, 32'h0, 32'h0, 1'b0, 1'b1, 2, 32'h8012_3456, 1'b0);
        run_op("lhu", 1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h0, 1'b1, 1'b1, 1, 32'h8001_0000, 1'b1);
        run_op("sb", 1'b1, 1'b1, 2'b00, 32'h201, 32'hAB, 32'h77, 1'b0, 1'b0, 1, 32'h0, 1'b0);
        run_op("lw1", 1'b1, 1'b0, 2'b10, 32'h400, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'hDEAD_BEEF, 1'b0);
        run_op("lw2", 1'b1, 1'b0, 2'b10, 32'h404, 32'h0, 32'h0, 1'b0, 1'b1, 3, 32'h1357_9BDF, 1'b0);
        run_op("sh", 1'b1, 1'b1, 2'b01, 32'h502, 32'hCAFE, 32'h9, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        run_op("lw11", 1'b1, 1'b0, 2'b11, 32'h600, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit mt = ($urandom_range(0, 3) != 0);
            bit rw = 1'($urandom);
            run_op($sformatf("rnd%0d", i), mt, rw, 2'($urandom), $urandom, $urandom, $urandom,
                   1'($urandom), rw ? 1'b0 : 1'b1, $urandom_range(1, 4), $urandom, 1'($urandom));
        end

        // Reset while an access is outstanding, then a stray ack
        @(negedge clk);
        mtype = 1'b1; mem_rw = 1'b0; width = 2'b10; addr = 32'h300; ack = 1'b0;
        @(negedge clk); #1;
        chk("midrst.busy_req", 32'(dc_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("midrst.req", 32'(dc_req), 32'd0);
        chk("midrst.rdata", dut.rdata_reg, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mtype = 1'b0; op_c = 32'h0000_A5A5; reg_we = 1'b1;
        ack = 1'b1; rdata_in = 32'hFFFF_0000; #1;
        chk("midrst.idle_req", 32'(dc_req), 32'd0);
        chk("midrst.idle_stall", 32'(stall), 32'd0);
        chk("midrst.pass", wb_wdata, 32'h0000_A5A5);
        @(negedge clk); ack = 1'b0; #1;
        chk("midrst.stray_ack", dut.rdata_reg, 32'd0);
        $display("midrst: reset in BUSY, stray ack ignored");

        // Misaligned word: suppressed when the check is built in, masked otherwise
        run_op("lw_mis", 1'b1, 1'b0, 2'b10, 32'h102, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h2468_ACE0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
